// File: rtl/calc_result_tx.sv
// Response framer: captures one ALU result per handshake and streams it out as an
// 8-byte frame (header, seq, data[31:0], status, xor checksum) on a byte-wide stream.
module calc_result_tx #(
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter logic [7:0] SEQ_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_data,
    input  logic [1:0]  res_err,
    input  logic [3:0]  res_op,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy
);

    typedef enum logic {Idle, Send} stateT;

    stateT       stateQ;
    logic [31:0] dataQ;
    logic [1:0]  errQ;
    logic [3:0]  opQ;
    logic [7:0]  seqQ;
    logic [2:0]  idxQ;

    logic [2:0]  nextIdx;
    logic [7:0]  statusByte;
    logic [7:0]  chkByte;
    logic [7:0]  nextByte;

    assign nextIdx = idxQ + 3'd1;

    // seqQ only advances after the last byte, so it doubles as the frame's shadow seq.
    always_comb begin
        statusByte = {opQ, 2'b00, errQ};
        chkByte    = seqQ ^ dataQ[31:24] ^ dataQ[23:16] ^ dataQ[15:8] ^ dataQ[7:0]
                     ^ statusByte;
    end

    always_comb begin
        nextByte = HEADER;
        unique case (nextIdx)
            3'd0: nextByte = HEADER;
            3'd1: nextByte = seqQ;
            3'd2: nextByte = dataQ[31:24];
            3'd3: nextByte = dataQ[23:16];
            3'd4: nextByte = dataQ[15:8];
            3'd5: nextByte = dataQ[7:0];
            3'd6: nextByte = statusByte;
            3'd7: nextByte = chkByte;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= Idle;
            dataQ     <= 32'h0;
            errQ      <= 2'b00;
            opQ       <= 4'h0;
            seqQ      <= SEQ_INIT;
            idxQ      <= 3'd0;
            res_ready <= 1'b1;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
        end else begin
            unique case (stateQ)
                Idle: begin
                    if (res_valid && res_ready) begin
                        dataQ     <= res_data;
                        errQ      <= res_err;
                        opQ       <= res_op;
                        idxQ      <= 3'd0;
                        tx_data   <= HEADER;
                        tx_valid  <= 1'b1;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                        stateQ    <= Send;
                    end
                end
                Send: begin
                    if (tx_valid && tx_ready) begin
                        if (idxQ == 3'd7) begin
                            // tx_data keeps the checksum byte while idle
                            idxQ      <= 3'd0;
                            seqQ      <= seqQ + 8'd1;
                            tx_valid  <= 1'b0;
                            res_ready <= 1'b1;
                            busy      <= 1'b0;
                            stateQ    <= Idle;
                        end else begin
                            idxQ    <= nextIdx;
                            tx_data <= nextByte;
                        end
                    end
                end
            endcase
        end
    end

endmodule
